// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Purpose:
//   Conditions one raw mechanical button or slide-switch pad signal for the
//   rest of the board logic. The pad is brought into the clk domain through a
//   two-flop synchronizer. A four-state FSM accepts a new level only after it
//   has held steady for DEBOUNCE_CYCLES consecutive synchronized samples.
//   The block produces a clean level, one-cycle press and release strobes,
//   and a latch that flips on every accepted press. Use one instance per
//   physical input.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a new level
//                    (legal range 2 .. 2^24; default is 10 ms at 100 MHz)
//   CNT_W            qualification counter width, 2^CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk          in   system clock (100 MHz board oscillator)
//   rst          in   synchronous active-high reset
//   btn_in       in   raw pad signal, asynchronous to clk and may bounce
//   btn_level    out  debounced level
//   btn_press    out  one-cycle strobe on an accepted 0->1 transition
//   btn_release  out  one-cycle strobe on an accepted 1->0 transition
//   btn_toggle   out  inverts on every btn_press
//
// All outputs are registered, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_toggle
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    // The counter runs from 0 up to this value while the candidate level holds.
    // A sample that still matches at this count completes the qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             press_next;
    logic             release_next;
    logic             toggle_next;

    // Two-flop synchronizer. Only s is used downstream, so the asynchronous
    // pad never reaches the FSM or the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= btn_in;
            s     <= sync1;
        end
    end

    // State register plus all registered outputs. Reset clears everything and
    // takes priority over any event in the same cycle. An in-progress
    // qualification is therefore discarded. A button still held through reset
    // is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STABLE_LOW;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_toggle  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
            btn_toggle  <= toggle_next;
        end
    end

    // Next-state and next-output logic.
    // The strobes default to 0, so each one is high for exactly one cycle.
    // Press and release are raised on mutually exclusive transitions, so they
    // can never be high together.
    // A WAIT state drops back to its STABLE state on any single deviating
    // sample, and the counter restarts from 0 on the next entry into WAIT.
    // The counter never goes past CNT_LAST, so it cannot wrap.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = btn_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        toggle_next  = btn_toggle;

        case (state)
            STABLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = '0;
                end
            end

            WAIT_HIGH: begin
                if (!s) begin
                    state_next = STABLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next  = STABLE_HIGH;
                    level_next  = 1'b1;
                    press_next  = 1'b1;
                    toggle_next = ~btn_toggle;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            STABLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = '0;
                end
            end

            WAIT_LOW: begin
                if (s) begin
                    state_next = STABLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next   = STABLE_LOW;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_next = STABLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Purpose:
//   Self-checking bench for button_debounce with DEBOUNCE_CYCLES=8, CNT_W=4.
//   Each scenario task records the strobes it expects as scoreboard entries
//   (kind and edge number, relative to the edge that first samples the new
//   btn_in value). Every press/release strobe the DUT emits is popped from
//   the scoreboard and compared. Level and toggle checks are done inline.
// ---------------------------------------------------------------------------
module tb_button_debounce;

    localparam int DEB = 8;

    typedef struct {
        bit is_press;
        int edge_num;
    } strobe_t;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_toggle;

    strobe_t sb[$];
    int      checks;
    int      fails;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_toggle (btn_toggle)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds rst for two edges with the given pad value. Returns 1 time unit
    // after the second edge.
    task automatic do_reset(input logic pad);
        rst    = 1'b1;
        btn_in = pad;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Checks that every output reads 0 right after reset.
    task automatic test_reset;
        do_reset(1'b0);
        checks++;
        if (btn_level !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_level: got %b, want 0", btn_level);
        end
        checks++;
        if (btn_press !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_press: got %b, want 0", btn_press);
        end
        checks++;
        if (btn_release !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release: got %b, want 0", btn_release);
        end
        checks++;
        if (btn_toggle !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_toggle: got %b, want 0", btn_toggle);
        end
    endtask

    // Clean press: btn_in held high from before edge 0. Level and press rise
    // after edge DEB+2, and press falls one edge later.
    task automatic test_clean_press;
        strobe_t want;
        do_reset(1'b0);
        btn_in = 1'b1;
        sb.push_back('{1'b1, DEB + 2});
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk); #1;
            if (btn_press || btn_release) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL clean_extra_strobe: edge %0d press=%b release=%b, want none", e, btn_press, btn_release);
                end else begin
                    want = sb.pop_front();
                    if (btn_press !== want.is_press || btn_release !== !want.is_press || e != want.edge_num) begin
                        fails++;
                        $display("[TB] FAIL clean_strobe: edge %0d press=%b release=%b, want press=%b at edge %0d", e, btn_press, btn_release, want.is_press, want.edge_num);
                    end
                end
            end
            if (e == DEB + 1) begin
                checks++;
                if (btn_level !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL clean_level_early: edge %0d got %b, want 0", e, btn_level);
                end
            end
            if (e == DEB + 2) begin
                checks++;
                if (btn_level !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL clean_level: edge %0d got %b, want 1", e, btn_level);
                end
            end
            if (e == DEB + 3) begin
                checks++;
                if (btn_press !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL clean_press_width: edge %0d got %b, want 0", e, btn_press);
                end
            end
        end
        checks++;
        if (btn_toggle !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clean_toggle: got %b, want 1", btn_toggle);
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL clean_missing_strobe: %0d outstanding, want 0", sb.size());
        end
        sb.delete();
    endtask

    // Bounce: btn_in is 1,0,1,0,1 on consecutive edges, then held at 1. The
    // final 0->1 sample is at edge 4, so the single press follows edge 4+DEB+2.
    task automatic test_bounce;
        strobe_t want;
        logic    pat[5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset(1'b0);
        btn_in = pat[0];
        sb.push_back('{1'b1, 4 + DEB + 2});
        for (int e = 0; e <= 25; e++) begin
            @(posedge clk); #1;
            if (btn_press || btn_release) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL bounce_extra_strobe: edge %0d press=%b release=%b, want none", e, btn_press, btn_release);
                end else begin
                    want = sb.pop_front();
                    if (btn_press !== want.is_press || btn_release !== !want.is_press || e != want.edge_num) begin
                        fails++;
                        $display("[TB] FAIL bounce_strobe: edge %0d press=%b release=%b, want press=%b at edge %0d", e, btn_press, btn_release, want.is_press, want.edge_num);
                    end
                end
            end
            if (e < 4) btn_in = pat[e + 1];
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL bounce_missing_strobe: %0d outstanding, want 0", sb.size());
        end
        checks++;
        if (btn_level !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bounce_level: got %b, want 1", btn_level);
        end
        sb.delete();
    endtask

    // Short glitch: btn_in high for 5 cycles only, so nothing is accepted.
    task automatic test_short_glitch;
        do_reset(1'b0);
        btn_in = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            checks++;
            if (btn_level !== 1'b0 || btn_press !== 1'b0 || btn_release !== 1'b0 || btn_toggle !== 1'b0) begin
                fails++;
                $display("[TB] FAIL glitch_outputs: edge %0d level=%b press=%b release=%b toggle=%b, want all 0", e, btn_level, btn_press, btn_release, btn_toggle);
            end
            if (e == 4) btn_in = 1'b0;
        end
    endtask

    // Release and toggle: two press/hold/release rounds. Each strobe follows
    // edge DEB+2 of its phase. Toggle reads 1 after the first press and 0
    // after the second.
    task automatic test_release_toggle;
        strobe_t want;
        logic    exp_toggle;
        do_reset(1'b0);
        exp_toggle = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int ph = 0; ph < 2; ph++) begin
                btn_in = (ph == 0);
                if (ph == 0) exp_toggle = ~exp_toggle;
                sb.push_back('{ph == 0, DEB + 2});
                for (int e = 0; e <= 20; e++) begin
                    @(posedge clk); #1;
                    checks++;
                    if (btn_press && btn_release) begin
                        fails++;
                        $display("[TB] FAIL toggle_overlap: round %0d edge %0d press and release both high", r, e);
                    end
                    if (btn_press || btn_release) begin
                        checks++;
                        if (sb.size() == 0) begin
                            fails++;
                            $display("[TB] FAIL toggle_extra_strobe: round %0d edge %0d press=%b release=%b, want none", r, e, btn_press, btn_release);
                        end else begin
                            want = sb.pop_front();
                            if (btn_press !== want.is_press || btn_release !== !want.is_press || e != want.edge_num) begin
                                fails++;
                                $display("[TB] FAIL toggle_strobe: round %0d edge %0d press=%b release=%b, want press=%b at edge %0d", r, e, btn_press, btn_release, want.is_press, want.edge_num);
                            end
                        end
                    end
                    if (e == DEB + 3) begin
                        checks++;
                        if (btn_level !== (ph == 0) || btn_toggle !== exp_toggle) begin
                            fails++;
                            $display("[TB] FAIL toggle_state: round %0d phase %0d level=%b toggle=%b, want level=%b toggle=%b", r, ph, btn_level, btn_toggle, ph == 0, exp_toggle);
                        end
                    end
                end
                checks++;
                if (sb.size() != 0) begin
                    fails++;
                    $display("[TB] FAIL toggle_missing_strobe: round %0d phase %0d, %0d outstanding", r, ph, sb.size());
                    sb.delete();
                end
            end
        end
    endtask

    // Reset mid-qualification: rst is high at edge 5 only, with btn_in held
    // high. Edge 6 is the first edge after reset, so the press follows edge
    // 6+DEB+2.
    task automatic test_reset_mid_qual;
        strobe_t want;
        do_reset(1'b0);
        btn_in = 1'b1;
        sb.push_back('{1'b1, 6 + DEB + 2});
        for (int e = 0; e <= 22; e++) begin
            @(posedge clk); #1;
            if (e == 5) begin
                rst = 1'b0;
                checks++;
                if (btn_level !== 1'b0 || btn_press !== 1'b0 || btn_release !== 1'b0 || btn_toggle !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL midrst_outputs: level=%b press=%b release=%b toggle=%b, want all 0", btn_level, btn_press, btn_release, btn_toggle);
                end
            end
            if (btn_press || btn_release) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL midrst_extra_strobe: edge %0d press=%b release=%b, want none", e, btn_press, btn_release);
                end else begin
                    want = sb.pop_front();
                    if (btn_press !== want.is_press || btn_release !== !want.is_press || e != want.edge_num) begin
                        fails++;
                        $display("[TB] FAIL midrst_strobe: edge %0d press=%b release=%b, want press=%b at edge %0d", e, btn_press, btn_release, want.is_press, want.edge_num);
                    end
                end
            end
            if (e == 4) rst = 1'b1;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL midrst_missing_strobe: %0d outstanding, want 0", sb.size());
        end
        sb.delete();
    endtask

    // Reset during stable high: with btn_in dropped at the same time as rst,
    // all outputs clear and no release strobe may ever follow.
    task automatic test_reset_stable_high;
        strobe_t want;
        do_reset(1'b0);
        btn_in = 1'b1;
        sb.push_back('{1'b1, DEB + 2});
        for (int e = 0; e <= 14; e++) begin
            @(posedge clk); #1;
            if (btn_press || btn_release) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL hirst_extra_strobe: edge %0d press=%b release=%b, want none", e, btn_press, btn_release);
                end else begin
                    want = sb.pop_front();
                    if (btn_press !== want.is_press || btn_release !== !want.is_press || e != want.edge_num) begin
                        fails++;
                        $display("[TB] FAIL hirst_strobe: edge %0d press=%b release=%b, want press=%b at edge %0d", e, btn_press, btn_release, want.is_press, want.edge_num);
                    end
                end
            end
        end
        checks++;
        if (btn_level !== 1'b1 || btn_toggle !== 1'b1 || sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL hirst_pre_state: level=%b toggle=%b outstanding=%0d, want 1 1 0", btn_level, btn_toggle, sb.size());
        end
        sb.delete();
        btn_in = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (btn_level !== 1'b0 || btn_press !== 1'b0 || btn_release !== 1'b0 || btn_toggle !== 1'b0) begin
            fails++;
            $display("[TB] FAIL hirst_outputs: level=%b press=%b release=%b toggle=%b, want all 0", btn_level, btn_press, btn_release, btn_toggle);
        end
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            checks++;
            if (btn_release !== 1'b0 || btn_press !== 1'b0 || btn_level !== 1'b0) begin
                fails++;
                $display("[TB] FAIL hirst_after: edge %0d level=%b press=%b release=%b, want all 0", e, btn_level, btn_press, btn_release);
            end
        end
    endtask

    // Runs every scenario in sequence and prints the summary line.
    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        btn_in = 1'b0;
        @(posedge clk); #1;
        $display("[TB] starting button_debounce scenarios");
        test_reset;
        test_clean_press;
        test_bounce;
        test_short_glitch;
        test_release_toggle;
        test_reset_mid_qual;
        test_reset_stable_high;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
